// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: multi-precision adder controller. It adds two NBYTES-limb
// operands one byte at a time through a single external 8-bit adder that has no
// carry-in port. A pending carry is folded in by a second "+1" pass (INC) through
// the same adder. The number of adder passes is reported so that different adder
// builds can be compared on the same stimulus.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any operation in flight
//   start      request an add; taken only in IDLE
//   a, b       operands, captured on the accepting edge
//   busy       high from the cycle after accept through DONE
//   done       one-cycle pulse; result and cyc_count valid
//   result     a+b, MSB is the final carry; built limb by limb
//   cyc_count  adder passes (ADD+INC) of the last operation, saturating
//   cla_a/b    adder operands, combinational from state
//   cla_sum    9-bit adder result, same cycle
module cla_word_sequencer #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned CNTW   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES:0]     result,
  output logic [CNTW-1:0]       cyc_count,
  output logic [7:0]            cla_a,
  output logic [7:0]            cla_b,
  input  logic [8:0]            cla_sum
);

  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, INC, DONE} state_t;

  state_t                   state;
  logic [NBYTES-1:0][7:0]   a_q;
  logic [NBYTES-1:0][7:0]   b_q;
  logic [NBYTES-1:0][7:0]   res_limbs;
  logic                     res_carry;
  logic [IDXW-1:0]          idx;
  logic                     carry;
  logic [8:0]               partial;
  logic [CNTW-1:0]          cnt;

  logic [CNTW-1:0]          cnt_inc;
  logic                     adv;
  logic                     adv_carry;
  logic                     last;

  assign result = {res_carry, res_limbs};

  // Saturating pass counter increment
  assign cnt_inc = (cnt == {CNTW{1'b1}}) ? cnt : cnt + CNTW'(1);

  assign last = (idx == IDXW'(NBYTES - 1));

  // A limb is finished after ADD with no pending carry, or after INC.
  // At most one of partial[8] and the INC carry-out can be set (0x1FE+1 < 0x200).
  always_comb begin
    adv       = 1'b0;
    adv_carry = cla_sum[8];
    case (state)
      ADD: adv = ~carry;
      INC: begin
        adv       = 1'b1;
        adv_carry = partial[8] | cla_sum[8];
      end
      default: adv = 1'b0;
    endcase
  end

  // Adder operand steering
  always_comb begin
    cla_a = 8'h00;
    cla_b = 8'h00;
    case (state)
      ADD: begin
        cla_a = a_q[idx];
        cla_b = b_q[idx];
      end
      INC: begin
        cla_a = partial[7:0];
        cla_b = 8'h01;
      end
      default: begin
        cla_a = 8'h00;
        cla_b = 8'h00;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_limbs <= '0;
      res_carry <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      partial   <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cyc_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            res_limbs <= '0;
            res_carry <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ADD;
          end
        end
        ADD: begin
          cnt <= cnt_inc;
          if (carry) begin
            partial <= cla_sum;
            state   <= INC;
          end
        end
        INC: begin
          cnt <= cnt_inc;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Close out the current limb and move on
      if (adv) begin
        res_limbs[idx] <= cla_sum[7:0];
        carry          <= adv_carry;
        if (last) begin
          res_carry <= adv_carry;
          cyc_count <= cnt_inc;
          done      <= 1'b1;
          state     <= DONE;
        end else begin
          idx   <= idx + IDXW'(1);
          state <= ADD;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed bench for cla_word_sequencer with NBYTES=4, plus a short run of
// random operand pairs checked against a prefix-carry model.
module tb_cla_word_sequencer;

  localparam int unsigned NB = 4;
  localparam int unsigned CW = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [8*NB-1:0]   a;
  logic [8*NB-1:0]   b;
  logic              busy;
  logic              done;
  logic [8*NB:0]     result;
  logic [CW-1:0]     cyc_count;
  logic [7:0]        cla_a;
  logic [7:0]        cla_b;
  logic [8:0]        cla_sum;

  int checks = 0;
  int errors = 0;

  cla_word_sequencer #(.NBYTES(NB), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cyc_count(cyc_count),
    .cla_a(cla_a), .cla_b(cla_b), .cla_sum(cla_sum)
  );

  // External 8+8 -> 9 adder
  assign cla_sum = {1'b0, cla_a} + {1'b0, cla_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Drives start, waits for done (bounded) and returns the
  // latency counted in cycles from the accept cycle. inj_at>0 pulses a second
  // start (0x17+0x64) at that cycle while busy.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input int inj_at, output int lat);
    start = 1'b1;
    a     = av;
    b     = bv;
    lat   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
        chk({tag, "_cla_a_limb0"}, 64'(cla_a), 64'(av[7:0]));
        chk({tag, "_cla_b_limb0"}, 64'(cla_b), 64'(bv[7:0]));
      end
      if (inj_at > 0 && k == inj_at) begin
        start = 1'b1;
        a     = 32'h0000_0017;
        b     = 32'h0000_0064;
      end else if (inj_at > 0 && k == inj_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_done_timeout observed=no_done expected=done", tag);
    end
  endtask

  // After done: the pulse must last exactly one cycle and busy must drop
  task automatic chk_after_done(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_busy_drop"}, 64'(busy), 64'd0);
  endtask

  int          lat;
  logic [31:0] ra, rb;
  logic [32:0] exp_res;
  int          exp_cyc;
  logic [32:0] pre;
  logic [31:0] msk;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cyc", 64'(cyc_count), 64'd0);
    chk("rst_cla_a", 64'(cla_a), 64'd0);
    chk("rst_cla_b", 64'(cla_b), 64'd0);

    // 1: carry out of limb 0 forces one INC on limb 1
    run_op("t1", 32'h0000_00FF, 32'h0000_007A, 0, lat);
    chk("t1_result", 64'(result), 64'h0_0000_0179);
    chk("t1_cyc", 64'(cyc_count), 64'd5);
    chk("t1_latency", 64'(lat), 64'd6);
    chk_after_done("t1");

    // 2: carry ripples through every limb, INC on limbs 1..3
    run_op("t2", 32'hFFFF_FFFF, 32'h0000_0001, 0, lat);
    chk("t2_result", 64'(result), 64'h1_0000_0000);
    chk("t2_cyc", 64'(cyc_count), 64'd7);
    chk("t2_latency", 64'(lat), 64'd8);
    chk_after_done("t2");

    // 3: no carry anywhere, minimum latency
    run_op("t3", 32'h0000_000C, 32'h0000_007C, 0, lat);
    chk("t3_result", 64'(result), 64'h0_0000_0088);
    chk("t3_cyc", 64'(cyc_count), 64'd4);
    chk("t3_latency", 64'(lat), 64'd5);
    chk_after_done("t3");

    // 4: start while busy is ignored, then a fresh start is taken
    run_op("t4a", 32'h0000_00C8, 32'h0000_001E, 2, lat);
    chk("t4a_result", 64'(result), 64'h0_0000_00E6);
    chk("t4a_cyc", 64'(cyc_count), 64'd4);
    chk_after_done("t4a");
    run_op("t4b", 32'h0000_0017, 32'h0000_0064, 0, lat);
    chk("t4b_result", 64'(result), 64'h0_0000_007B);
    chk("t4b_latency", 64'(lat), 64'd5);
    chk_after_done("t4b");

    // 5: reset during the INC pass of limb 1 of test 2
    start = 1'b1;
    a     = 32'hFFFF_FFFF;
    b     = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("t5_inc_cla_a", 64'(cla_a), 64'hFF);
    chk("t5_inc_cla_b", 64'(cla_b), 64'h01);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_result", 64'(result), 64'd0);
    chk("t5_cyc", 64'(cyc_count), 64'd0);
    chk("t5_cla_a", 64'(cla_a), 64'd0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("t5_no_done", 64'(done), 64'd0);
    end
    run_op("t5b", 32'h1234_5678, 32'h0FED_CBA9, 0, lat);
    chk("t5b_result", 64'(result), 64'h0_2222_2221);
    chk("t5b_cyc", 64'(cyc_count), 64'd7);
    chk_after_done("t5b");

    // 6: random pairs against a prefix-carry model
    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 4 == 0) rb = ~ra + 32'(n & 1);
      exp_res = {1'b0, ra} + {1'b0, rb};
      exp_cyc = NB;
      for (int i = 1; i < NB; i++) begin
        msk = (32'h1 << (8 * i)) - 32'h1;
        pre = {1'b0, ra & msk} + {1'b0, rb & msk};
        if (pre[8*i]) exp_cyc++;
      end
      run_op("rnd", ra, rb, 0, lat);
      chk("rnd_result", 64'(result), 64'(exp_res));
      chk("rnd_cyc", 64'(cyc_count), 64'(exp_cyc));
      chk("rnd_latency", 64'(lat), 64'(exp_cyc + 1));
      @(posedge clk);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
